// File: rtl/qar_irq_ctrl.sv
// External interrupt aggregator: synchronises peripheral lines, latches level/edge pending,
// arbitrates by fixed priority and exposes claim/complete through a small register window.
module qar_irq_ctrl #(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned ID_W    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic               irq_external,
    input  logic               irq_external_ack,
    input  logic               reg_cs,
    input  logic               mem_valid,
    input  logic               mem_we,
    input  logic [4:0]         mem_addr,
    input  logic [31:0]        mem_wdata,
    output logic               mem_ready,
    output logic [31:0]        mem_rdata,
    output logic [ID_W-1:0]    claim_id
);

    localparam logic [2:0] AddrPending  = 3'd0;
    localparam logic [2:0] AddrEnable   = 3'd1;
    localparam logic [2:0] AddrEdge     = 3'd2;
    localparam logic [2:0] AddrClaim    = 3'd3;
    localparam logic [2:0] AddrComplete = 3'd4;

    logic [NUM_SRC-1:0] sync1_q, sync2_q, sync2_prev_q;
    logic [NUM_SRC-1:0] edge_pend_q, edge_pend_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] edge_q, edge_d;
    logic               in_service_q, in_service_d;
    logic [ID_W-1:0]    claim_id_q, claim_id_d;
    logic               irq_q, irq_d;
    logic               ack_q;
    logic               ready_q, ready_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] win_oh;
    logic [NUM_SRC-1:0] w1c_mask;
    logic [NUM_SRC-1:0] clr_mask;
    logic [NUM_SRC-1:0] wdata_src;
    logic [ID_W-1:0]    win_id;
    logic [2:0]         reg_sel;
    logic               accept;
    logic               wr_en;
    logic               rd_en;
    logic               ack_rise;
    logic               claim;
    logic               complete;
    logic               unused_bus;

    // Byte-lane bits and data bits beyond the source count carry no meaning here.
    assign unused_bus = ^{mem_addr[1:0], mem_wdata};

    assign reg_sel   = mem_addr[4:2];
    assign wdata_src = mem_wdata[NUM_SRC-1:0];
    assign accept    = reg_cs & mem_valid & ~ready_q;
    assign wr_en     = accept & mem_we;
    assign rd_en     = accept & ~mem_we;
    assign ack_rise  = irq_external_ack & ~ack_q;

    // Level sources mirror the synchronised line; edge sources use the sticky latch.
    assign pend   = (edge_q & edge_pend_q) | (~edge_q & sync2_q);
    assign active = pend & enable_q;

    always_comb begin
        win_id = '0;
        win_oh = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (active[i]) begin
                win_id    = ID_W'(i + 1);
                win_oh    = '0;
                win_oh[i] = 1'b1;
            end
        end
    end

    assign claim    = ack_rise & ~in_service_q & (active != '0);
    assign complete = wr_en & (reg_sel == AddrComplete) & in_service_q &
                      (mem_wdata[ID_W-1:0] == claim_id_q);

    always_comb begin
        w1c_mask = '0;
        if (wr_en && (reg_sel == AddrPending)) begin
            w1c_mask = wdata_src & edge_q;
        end
        clr_mask = w1c_mask | (claim ? win_oh : '0);
        // A new edge in the same cycle as a clear must not be lost.
        edge_pend_d = (edge_pend_q & ~clr_mask) | (edge_q & sync2_q & ~sync2_prev_q);
    end

    always_comb begin
        enable_d = enable_q;
        edge_d   = edge_q;
        if (wr_en && (reg_sel == AddrEnable)) begin
            enable_d = wdata_src;
        end
        if (wr_en && (reg_sel == AddrEdge)) begin
            edge_d = wdata_src;
        end
    end

    always_comb begin
        in_service_d = in_service_q;
        claim_id_d   = claim_id_q;
        if (claim) begin
            in_service_d = 1'b1;
            claim_id_d   = win_id;
        end else if (complete) begin
            in_service_d = 1'b0;
            claim_id_d   = '0;
        end
    end

    assign irq_d   = (active != '0) & ~in_service_q;
    assign ready_d = accept;

    always_comb begin
        rdata_d = '0;
        if (rd_en) begin
            case (reg_sel)
                AddrPending: rdata_d = 32'(pend);
                AddrEnable:  rdata_d = 32'(enable_q);
                AddrEdge:    rdata_d = 32'(edge_q);
                AddrClaim:   rdata_d = {in_service_q, 31'(claim_id_q)};
                default:     rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            sync2_prev_q <= '0;
            ack_q        <= 1'b0;
        end else begin
            sync1_q      <= irq_src;
            sync2_q      <= sync1_q;
            sync2_prev_q <= sync2_q;
            ack_q        <= irq_external_ack;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_pend_q  <= '0;
            enable_q     <= '0;
            edge_q       <= '0;
            in_service_q <= 1'b0;
            claim_id_q   <= '0;
            irq_q        <= 1'b0;
            ready_q      <= 1'b0;
            rdata_q      <= '0;
        end else begin
            edge_pend_q  <= edge_pend_d;
            enable_q     <= enable_d;
            edge_q       <= edge_d;
            in_service_q <= in_service_d;
            claim_id_q   <= claim_id_d;
            irq_q        <= irq_d;
            ready_q      <= ready_d;
            rdata_q      <= rdata_d;
        end
    end

    assign irq_external = irq_q;
    assign mem_ready    = ready_q;
    assign mem_rdata    = rdata_q;
    assign claim_id     = claim_id_q;

endmodule

// File: tb/tb_qar_irq_ctrl.sv
// Directed and randomised bench for qar_irq_ctrl, checked against a per-cycle behavioural model.
module tb_qar_irq_ctrl;

    localparam int unsigned NumSrc = 8;
    localparam int unsigned IdW    = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NumSrc-1:0] irq_src = '0;
    logic              irq_external;
    logic              irq_external_ack = 1'b0;
    logic              reg_cs = 1'b0;
    logic              mem_valid = 1'b0;
    logic              mem_we = 1'b0;
    logic [4:0]        mem_addr = '0;
    logic [31:0]       mem_wdata = '0;
    logic              mem_ready;
    logic [31:0]       mem_rdata;
    logic [IdW-1:0]    claim_id;

    int n_pass = 0;
    int n_total = 0;

    // Model: samples of irq_src taken 1, 2 and 3 edges ago, plus architectural state.
    logic [7:0]  h1, h2, h3;
    logic [7:0]  m_ep, m_en, m_edge;
    logic        m_insvc, m_irq, m_ackp, m_ready;
    logic [4:0]  m_claim;
    logic [31:0] m_rdata;

    always #5 clk = ~clk;

    qar_irq_ctrl #(
        .NUM_SRC (NumSrc),
        .ID_W    (IdW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .irq_src          (irq_src),
        .irq_external     (irq_external),
        .irq_external_ack (irq_external_ack),
        .reg_cs           (reg_cs),
        .mem_valid        (mem_valid),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_ready        (mem_ready),
        .mem_rdata        (mem_rdata),
        .claim_id         (claim_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        h1 = '0; h2 = '0; h3 = '0;
        m_ep = '0; m_en = '0; m_edge = '0;
        m_insvc = 1'b0; m_irq = 1'b0; m_ackp = 1'b0; m_ready = 1'b0;
        m_claim = '0; m_rdata = '0;
    endtask

    task automatic model_step();
        logic [7:0]  pend, act, clr, new_ep;
        logic [31:0] new_rdata;
        logic        acc, claim_ev;
        logic [2:0]  sel;
        int          win;
        if (!rst_n) begin
            model_reset();
            return;
        end
        pend = 8'h00;
        for (int i = 0; i < 8; i++) pend[i] = m_edge[i] ? m_ep[i] : h2[i];
        act = pend & m_en;
        win = -1;
        for (int i = 0; i < 8; i++) begin
            if (act[i]) begin
                win = i;
                break;
            end
        end
        acc = reg_cs && mem_valid && !m_ready;
        sel = mem_addr[4:2];
        new_rdata = 32'h0;
        if (acc && !mem_we) begin
            case (sel)
                3'd0: new_rdata = {24'h0, pend};
                3'd1: new_rdata = {24'h0, m_en};
                3'd2: new_rdata = {24'h0, m_edge};
                3'd3: new_rdata = {m_insvc, 26'h0, m_claim};
                default: new_rdata = 32'h0;
            endcase
        end
        claim_ev = irq_external_ack && !m_ackp && !m_insvc && (win >= 0);
        clr = 8'h00;
        if (acc && mem_we && sel == 3'd0) clr = mem_wdata[7:0] & m_edge;
        if (claim_ev) clr[win] = 1'b1;
        new_ep = (m_ep & ~clr) | (m_edge & h2 & ~h3);
        m_irq = (act != 8'h00) && !m_insvc;
        if (claim_ev) begin
            m_insvc = 1'b1;
            m_claim = 5'(win + 1);
        end else if (acc && mem_we && sel == 3'd4 && m_insvc && mem_wdata[4:0] == m_claim) begin
            m_insvc = 1'b0;
            m_claim = '0;
        end
        if (acc && mem_we && sel == 3'd1) m_en = mem_wdata[7:0];
        if (acc && mem_we && sel == 3'd2) m_edge = mem_wdata[7:0];
        m_ep    = new_ep;
        m_ready = acc;
        m_rdata = new_rdata;
        m_ackp  = irq_external_ack;
        h3 = h2;
        h2 = h1;
        h1 = irq_src;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("irq_external", 32'(irq_external), 32'(m_irq));
        chk("mem_ready", 32'(mem_ready), 32'(m_ready));
        chk("mem_rdata", mem_rdata, m_rdata);
        chk("claim_id", 32'(claim_id), 32'(m_claim));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        reg_cs = 1'b1; mem_valid = 1'b1; mem_we = 1'b1; mem_addr = a; mem_wdata = d;
        tick();
        reg_cs = 1'b0; mem_valid = 1'b0; mem_we = 1'b0;
        tick();
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        reg_cs = 1'b1; mem_valid = 1'b1; mem_we = 1'b0; mem_addr = a;
        tick();
        d = mem_rdata;
        reg_cs = 1'b0; mem_valid = 1'b0;
        tick();
    endtask

    task automatic ack_pulse();
        irq_external_ack = 1'b1;
        tick();
        irq_external_ack = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] rd;
        model_reset();
        ticks(2);
        rst_n = 1'b1;
        tick();
        bus_read(5'h04, rd);
        chk("reset_enable", rd, 32'h0);

        // Level source 2.
        bus_write(5'h04, 32'h04);
        irq_src[2] = 1'b1;
        ticks(2);
        chk("lvl_irq_early", 32'(irq_external), 32'h0);
        tick();
        chk("lvl_irq_e2", 32'(irq_external), 32'h1);
        ack_pulse();
        bus_read(5'h0C, rd);
        chk("lvl_claim", rd, 32'h8000_0003);
        bus_write(5'h10, 32'd3);
        chk("lvl_reassert", 32'(irq_external), 32'h1);
        ack_pulse();
        irq_src[2] = 1'b0;
        ticks(3);
        bus_write(5'h10, 32'd3);
        ticks(2);
        chk("lvl_quiet", 32'(irq_external), 32'h0);

        // Edge sources 1 and 5 pulsed together.
        bus_write(5'h08, 32'h22);
        bus_write(5'h04, 32'h22);
        irq_src = 8'h22;
        tick();
        irq_src = 8'h00;
        ticks(3);
        bus_read(5'h00, rd);
        chk("edge_pending", rd, 32'h22);
        ack_pulse();
        chk("edge_claim1", 32'(claim_id), 32'd2);
        bus_read(5'h00, rd);
        chk("edge_pending_after1", rd, 32'h20);
        bus_write(5'h10, 32'd2);
        ack_pulse();
        chk("edge_claim2", 32'(claim_id), 32'd6);
        bus_read(5'h00, rd);
        chk("edge_pending_after2", rd, 32'h0);
        bus_write(5'h10, 32'd6);

        // Masking of edge source 0.
        bus_write(5'h08, 32'h01);
        bus_write(5'h04, 32'h00);
        irq_src[0] = 1'b1;
        tick();
        irq_src[0] = 1'b0;
        ticks(3);
        chk("mask_low", 32'(irq_external), 32'h0);
        bus_write(5'h04, 32'h01);
        chk("mask_unmasked", 32'(irq_external), 32'h1);
        bus_write(5'h00, 32'h01);
        chk("mask_w1c", 32'(irq_external), 32'h0);

        // Edge set on source 3 collides with its W1C.
        bus_write(5'h08, 32'h08);
        irq_src[3] = 1'b1;
        tick();
        irq_src[3] = 1'b0;
        tick();
        bus_write(5'h00, 32'h08);
        bus_read(5'h00, rd);
        chk("collision_set_wins", rd, 32'h08);
        bus_write(5'h00, 32'h08);
        bus_read(5'h00, rd);
        chk("collision_cleared", rd, 32'h0);

        // Completion discipline.
        bus_write(5'h08, 32'h00);
        bus_write(5'h04, 32'h04);
        irq_src[2] = 1'b1;
        ticks(3);
        ack_pulse();
        bus_write(5'h10, 32'd5);
        bus_read(5'h0C, rd);
        chk("wrong_complete", rd, 32'h8000_0003);
        bus_write(5'h10, 32'd3);
        ticks(2);
        irq_external_ack = 1'b1;
        ticks(2);
        bus_write(5'h10, 32'd3);
        ticks(6);
        bus_read(5'h0C, rd);
        chk("held_ack_once", rd, 32'h0);
        irq_external_ack = 1'b0;
        irq_src = 8'h00;
        ticks(3);
        ack_pulse();
        bus_read(5'h0C, rd);
        chk("ack_nothing", rd, 32'h0);

        // Bus corners.
        bus_read(5'h18, rd);
        chk("reserved_read", rd, 32'h0);
        bus_write(5'h04, 32'hFFFF_FFFF);
        bus_read(5'h04, rd);
        chk("enable_width", rd, 32'h0000_00FF);
        bus_write(5'h08, 32'h0F);

        // Reset in the middle of a read completion.
        reg_cs = 1'b1; mem_valid = 1'b1; mem_we = 1'b0; mem_addr = 5'h04;
        tick();
        chk("pre_reset_ready", 32'(mem_ready), 32'h1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("reset_ready_drop", 32'(mem_ready), 32'h0);
        chk("reset_rdata", mem_rdata, 32'h0);
        reg_cs = 1'b0; mem_valid = 1'b0;
        tick();
        #3;
        rst_n = 1'b1;
        tick();
        bus_read(5'h04, rd);
        chk("post_reset_enable", rd, 32'h0);
        bus_read(5'h08, rd);
        chk("post_reset_edge", rd, 32'h0);
        bus_read(5'h00, rd);
        chk("post_reset_pending", rd, 32'h0);
        bus_read(5'h0C, rd);
        chk("post_reset_claim", rd, 32'h0);

        // Randomised traffic against the model.
        for (int c = 0; c < 800; c++) begin
            irq_src = irq_src ^ 8'($urandom_range(0, 255) & $urandom_range(0, 255) &
                                   $urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) irq_external_ack = ~irq_external_ack;
            reg_cs    = 1'($urandom_range(0, 1));
            mem_valid = ($urandom_range(0, 3) != 0);
            mem_we    = 1'($urandom_range(0, 1));
            mem_addr  = 5'($urandom_range(0, 31));
            mem_wdata = $urandom();
            if (mem_addr[4:2] == 3'd4 && $urandom_range(0, 1) == 1) mem_wdata = {27'h0, m_claim};
            tick();
        end
        reg_cs = 1'b0; mem_valid = 1'b0;
        ticks(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/qar_irq_ctrl.md
# qar_irq_ctrl

External interrupt aggregator directly upstream of the QAR-Core `irq_external`/`irq_external_ack` pair. It synchronises up to `NUM_SRC` asynchronous peripheral interrupt lines and latches them per source as level or edge. It arbitrates by fixed priority (lowest index wins) and drives the core's single external interrupt line. Firmware configures it, claims and completes interrupts through a small memory-mapped register window on the core data bus.

## Interface
Parameters:
- `NUM_SRC`, 8: number of interrupt sources, 1..31.
- `ID_W`, 5: width of source ID field. ID = source index + 1; 0 means "none".

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `irq_src`  in  NUM_SRC  raw asynchronous interrupt requests, active high.
- `irq_external`  out  1  to core; request pending.
- `irq_external_ack`  in  1  from core; rising edge = interrupt taken.
- `reg_cs`  in  1  chip select from fabric address decoder.
- `mem_valid`  in  1  core bus request valid.
- `mem_we`  in  1  write enable.
- `mem_addr`  in  5  byte offset within window, bits [4:2] select the register.
- `mem_wdata`  in  32  write data.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_rdata`  out  32  read data, valid while `mem_ready`=1, else 0.
- `claim_id`  out  ID_W  ID currently in service, 0 if none. Debug/visibility.

## Operation
- Sync: each `irq_src` bit goes through a 2-flop synchroniser (`s1`→`s2`). `s2_q` holds the previous `s2` for edge detection.
- Pending, per source i:
  - EDGE[i]=0 (level): `pend[i]` = `s2[i]`. W1C has no effect.
  - EDGE[i]=1: `pend[i]` is set on `s2[i] & ~s2_q[i]`. It is cleared by a W1C to PENDING or by a claim of ID i+1. If a set and a clear occur in the same cycle, set wins.
- Active = `pend & ENABLE`. Winner = lowest set bit of active.
- `irq_external` is registered: next = (active≠0) & ~in_service.
- Claim: on `irq_external_ack & ~ack_q`:
  - If active≠0: `claim_id` ← winner+1, `in_service` ← 1, and the winner's edge pending is cleared.
  - If active=0 (race): no state change.
- Complete: a write to COMPLETE with `wdata[ID_W-1:0]`==`claim_id` clears `in_service` and `claim_id`. A mismatched write is ignored.
- Level sources still asserted after complete re-raise `irq_external` per the rule above.
- Registers (offset, access):
  - 0x00 PENDING: read `pend`; write W1C on edge bits.
  - 0x04 ENABLE: R/W.
  - 0x08 EDGE: R/W.
  - 0x0C CLAIM: read-only, `{in_service, 26'b0, claim_id}` (`in_service` at bit 31).
  - 0x10 COMPLETE: write-only, reads 0.
  - 0x14–0x1C: reserved; read 0, writes ignored.
- Bits ≥ NUM_SRC read 0 and are ignored on write.
- Bus: a request is accepted when `reg_cs & mem_valid & ~mem_ready`. The write takes effect, or read data is captured, at that edge. `mem_ready` is high for exactly the following cycle. Back-to-back requests therefore complete every 2 cycles.

## Timing
- Reset values (async): all sync flops, `pend`, ENABLE, EDGE, `in_service`, `claim_id`, `irq_external`, `mem_ready`, `mem_rdata` = 0. All sources are disabled and level mode after reset.
- Latency: `irq_src` rises and is stable before edge E0. Then:
  - `s1` is set at E0 and `s2` at E1.
  - `pend` is visible at E1 (level) or E2 (edge).
  - `irq_external` is high after E2 (level) or E3 (edge).
- Ack edge at edge A: `in_service` and `claim_id` update at A; `irq_external` is low after A+1.
- Complete write accepted at edge W: `in_service` clears at W; `irq_external` can re-assert after W+1.
- ENABLE write masks or unmasks with 1-cycle registered effect on `irq_external`.
- Held ack (level high) claims only once. A new claim requires ack to fall and rise again.
- Ack while `in_service`=1: ignored, claim unchanged.
- Reset asserted mid-transaction: `mem_ready` drops immediately and the transaction is lost. The core is reset by the same `rst_n`.

## Test plan
- Level source 2: ENABLE=0x04, drive `irq_src[2]`=1 → `irq_external`=1 three edges later. Pulse ack → CLAIM reads 0x80000003. Write COMPLETE=3 with source still high → `irq_external` re-asserts. Drop source, then complete → stays 0.
- Edge sources 1 and 5: EDGE=0x22, ENABLE=0x22, single-cycle pulses on both in the same cycle → PENDING=0x22. Ack → `claim_id`=2 and PENDING=0x20. Complete 2 → second ack yields `claim_id`=6 and PENDING=0.
- Masking: source 0 pending with ENABLE=0 → `irq_external`=0. Write ENABLE=1 → high within 2 cycles. W1C PENDING=0x01 in edge mode → low.
- Same-cycle collision: edge pulse on source 3 in the same cycle as a W1C of bit 3 → `pend[3]` stays 1.
- Completion discipline: wrong COMPLETE ID (5 while 3 in service) → `in_service` stays 1. Ack held high for 10 cycles → exactly one claim. Ack with nothing active → CLAIM reads 0.
- Bus and reset: read reserved 0x18 → 0. Write ENABLE=0xFFFFFFFF with NUM_SRC=8 → reads 0x000000FF. Assert `rst_n`=0 mid-read → `mem_ready`=0 and all registers 0.
